// File: rtl/mm_io_pkg.sv
// Shared register offsets and bit positions for the memory-mapped I/O responder.
package mm_io_pkg;

    localparam logic [2:0] OFF_LED  = 3'd0;
    localparam logic [2:0] OFF_SW   = 3'd1;
    localparam logic [2:0] OFF_TCNT = 3'd2;
    localparam logic [2:0] OFF_TCMP = 3'd3;
    localparam logic [2:0] OFF_TCTL = 3'd4;
    localparam logic [2:0] OFF_TXD  = 3'd5;
    localparam logic [2:0] OFF_TXS  = 3'd6;

    localparam int TCTL_EN  = 0;
    localparam int TCTL_AR  = 1;
    localparam int TCTL_EXP = 2;
    localparam int TCTL_IE  = 3;

    localparam int TXS_EMPTY   = 0;
    localparam int TXS_FULL    = 1;
    localparam int TXS_OVF     = 2;
    localparam int TXS_CNT_LSB = 4;

endpackage

// File: rtl/mm_tx_fifo.sv
// Byte FIFO; a push is visible on dout one cycle later. A push while full is taken only
// if a pop happens in the same cycle, otherwise it is ignored.
module mm_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [7:0]                   din,
    output logic [7:0]                   dout,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Gate with empty so the output is zero after reset and after draining.
    assign dout    = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mm_io_responder.sv
// CPU-bus register block: LED, switches, timer and TX FIFO. Reads are combinational in the
// mm_re cycle; writes land at the next edge. The TX stream stalls while tx_rdy is low.
module mm_io_responder
    import mm_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hC000,
    parameter int          LED_W      = 10,
    parameter int          SW_W       = 10,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mm_re,
    input  logic             mm_we,
    input  logic [15:0]      addr,
    input  logic [15:0]      wdata,
    output logic [15:0]      rdata,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] ledr,
    output logic [7:0]       tx_data,
    output logic             tx_vld,
    input  logic             tx_rdy,
    output logic             irq
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [LED_W-1:0] led_q, led_d;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    logic [15:0]      tcnt_q, tcnt_d, tcmp_q, tcmp_d;
    logic             en_q, en_d, ar_q, ar_d, ie_q, ie_d, exp_q, exp_d;
    logic             ovf_q, ovf_d;

    logic             hit, wr;
    logic [2:0]       off;
    logic             fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic [CW-1:0]    fifo_count;
    logic [3:0]       cnt4;
    logic [15:0]      status;

    assign hit = (addr[15:3] == BASE_ADDR[15:3]);
    assign off = addr[2:0];
    assign wr  = mm_we && hit;

    assign fifo_push = wr && (off == OFF_TXD);
    assign fifo_pop  = tx_vld && tx_rdy;
    assign tx_vld    = !fifo_empty;
    assign ledr      = led_q;
    assign irq       = exp_q && ie_q;

    mm_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (tx_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        cnt4   = 4'(fifo_count);
        status = 16'h0000;
        status[TXS_EMPTY] = fifo_empty;
        status[TXS_FULL]  = fifo_full;
        status[TXS_OVF]   = ovf_q;
        status[TXS_CNT_LSB +: 4] = cnt4;
    end

    always_comb begin
        led_d  = led_q;
        tcnt_d = tcnt_q;
        tcmp_d = tcmp_q;
        en_d   = en_q;
        ar_d   = ar_q;
        ie_d   = ie_q;
        exp_d  = exp_q;
        ovf_d  = ovf_q;

        if (wr && off == OFF_LED)  led_d  = wdata[LED_W-1:0];
        if (wr && off == OFF_TCMP) tcmp_d = wdata;
        if (wr && off == OFF_TCTL) begin
            en_d = wdata[TCTL_EN];
            ar_d = wdata[TCTL_AR];
            ie_d = wdata[TCTL_IE];
            if (wdata[TCTL_EXP]) exp_d = 1'b0;
        end

        // Timer after the CPU write so expiry beats a clear, and a CPU enable write beats auto-disable.
        if (en_q) begin
            if (tcnt_q == tcmp_q) begin
                exp_d = 1'b1;
                if (ar_q)                           tcnt_d = 16'h0000;
                else if (!(wr && off == OFF_TCTL))  en_d   = 1'b0;
            end else begin
                tcnt_d = tcnt_q + 16'd1;
            end
        end
        if (wr && off == OFF_TCNT) tcnt_d = wdata;

        if (wr && off == OFF_TXS && wdata[TXS_OVF]) ovf_d = 1'b0;
        if (fifo_push && fifo_full && !fifo_pop)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            tcnt_q    <= '0;
            tcmp_q    <= '0;
            en_q      <= 1'b0;
            ar_q      <= 1'b0;
            ie_q      <= 1'b0;
            exp_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            tcnt_q    <= tcnt_d;
            tcmp_q    <= tcmp_d;
            en_q      <= en_d;
            ar_q      <= ar_d;
            ie_q      <= ie_d;
            exp_q     <= exp_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        rdata = 16'h0000;
        if (mm_re && hit) begin
            case (off)
                OFF_LED:  rdata = 16'(led_q);
                OFF_SW:   rdata = 16'(sw_sync_q);
                OFF_TCNT: rdata = tcnt_q;
                OFF_TCMP: rdata = tcmp_q;
                OFF_TCTL: rdata = {12'h000, ie_q, exp_q, ar_q, en_q};
                OFF_TXD:  rdata = status;
                OFF_TXS:  rdata = status;
                default:  rdata = 16'h0000;
            endcase
        end
    end

endmodule
